// File: rtl/rotor_slot_pkg.sv
// rotor_slot_pkg
// Shared types and constants for the rotor slot selector.
//   state_t    : occupancy class of the slot list (empty / partial / full)
//   MODE_EXCL  : only one rotor may be selected at a time
//   MODE_MULTI : up to SLOTS rotors, kept in press order
package rotor_slot_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic MODE_EXCL  = 1'b0;
  localparam logic MODE_MULTI = 1'b1;

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect
// Rising-edge detector and press classifier for the rotor buttons.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   i_button_sync  : synchronised button levels, bit i = rotor i
//   o_press        : button_sync & ~btn_prev (raw rising edges)
//   o_press_one    : exactly one button rose this cycle
//   o_press_multi  : two or more buttons rose this cycle
//   o_press_idx    : index of the rising button when o_press_one is set
module btn_edge_detect #(
  parameter int unsigned N_BTN = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_BTN-1:0]           i_button_sync,
  output logic [N_BTN-1:0]           o_press,
  output logic                       o_press_one,
  output logic                       o_press_multi,
  output logic [$clog2(N_BTN)-1:0]   o_press_idx
);

  localparam int unsigned IDX_W = $clog2(N_BTN);

  logic [N_BTN-1:0] r_btn_prev;
  // Low for the first cycle after reset so that buttons held through
  // reset release are captured into btn_prev without raising an event.
  logic             r_armed;
  logic [N_BTN-1:0] w_low_cleared;
  logic             w_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_prev <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_btn_prev <= i_button_sync;
      r_armed    <= 1'b1;
    end
  end

  assign o_press = i_button_sync & ~r_btn_prev;

  // x & (x-1) drops the lowest set bit; non-zero result means >= 2 bits.
  assign w_low_cleared = o_press & (o_press - 1'b1);
  assign w_any         = |o_press;

  assign o_press_one   = r_armed && w_any && (w_low_cleared == '0);
  assign o_press_multi = r_armed && (w_low_cleared != '0);

  always_comb begin
    o_press_idx = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (o_press[i]) o_press_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rotor_slot_fsm.sv
// rotor_slot_fsm
// Tracks which rotors are selected and the order they were selected in.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   button_sync  : synchronised button levels, bit i = rotor i
//   mode         : 0 exclusive, 1 ordered multi-select
//   lock         : ignore all press events while high
//   rotor_sel    : bit i set iff rotor i occupies a valid slot
//   slot_idx     : slot k rotor index at [k*IDX_W +: IDX_W], slot 0 = oldest
//   slot_vld     : bit k set iff slot k holds a rotor
//   sel_count    : number of valid slots
//   sel_full     : sel_count == SLOTS
//   reject       : one-cycle pulse when a press is refused
//   change       : one-cycle pulse when selection or slots change
module rotor_slot_fsm
  import rotor_slot_pkg::*;
#(
  parameter int unsigned N_BTN = 8,
  parameter int unsigned SLOTS = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_BTN-1:0]                    button_sync,
  input  logic                                mode,
  input  logic                                lock,
  output logic [N_BTN-1:0]                    rotor_sel,
  output logic [SLOTS*$clog2(N_BTN)-1:0]      slot_idx,
  output logic [SLOTS-1:0]                    slot_vld,
  output logic [$clog2(SLOTS+1)-1:0]          sel_count,
  output logic                                sel_full,
  output logic                                reject,
  output logic                                change
);

  localparam int unsigned IDX_W = $clog2(N_BTN);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  // Edge detection
  logic [N_BTN-1:0] w_press;
  logic             w_press_one;
  logic             w_press_multi;
  logic [IDX_W-1:0] w_press_idx;

  btn_edge_detect #(
    .N_BTN (N_BTN)
  ) u_edge (
    .clock         (clock),
    .reset         (reset),
    .i_button_sync (button_sync),
    .o_press       (w_press),
    .o_press_one   (w_press_one),
    .o_press_multi (w_press_multi),
    .o_press_idx   (w_press_idx)
  );

  // Registered state
  logic [N_BTN-1:0]       r_sel;
  logic [SLOTS*IDX_W-1:0] r_slot;
  logic [SLOTS-1:0]       r_vld;
  logic [CNT_W-1:0]       r_count;
  logic                   r_full;
  logic                   r_reject;
  logic                   r_change;
  logic                   r_mode;
  state_t                 r_state;

  // Next-state
  logic [N_BTN-1:0]       w_sel;
  logic [SLOTS*IDX_W-1:0] w_slot;
  logic [SLOTS-1:0]       w_vld;
  logic [CNT_W-1:0]       w_count;
  logic                   w_reject;
  logic                   w_change;
  state_t                 w_state;

  // Removal helpers: position of the pressed rotor and the slot list
  // with that entry squeezed out.
  int unsigned            w_hit_k;
  logic [SLOTS*IDX_W-1:0] w_rm_slot;
  logic [SLOTS-1:0]       w_rm_vld;
  logic [SLOTS*IDX_W-1:0] w_sh_slot;
  logic [SLOTS-1:0]       w_sh_vld;
  logic                   w_mode_chg;

  assign w_mode_chg = (mode != r_mode);

  always_comb begin
    w_hit_k = 0;
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (r_vld[j] && (r_slot[j*IDX_W +: IDX_W] == w_press_idx)) w_hit_k = j;
    end
  end

  // Shifting the packed list right by one field moves slot j+1 into slot j
  // and brings zeros into the top slot, so invalid slots stay zero.
  assign w_sh_slot = r_slot >> IDX_W;
  assign w_sh_vld  = r_vld >> 1;

  always_comb begin
    w_rm_slot = r_slot;
    w_rm_vld  = r_vld;
    for (int unsigned j = 0; j < SLOTS; j++) begin
      if (j >= w_hit_k) begin
        w_rm_slot[j*IDX_W +: IDX_W] = w_sh_slot[j*IDX_W +: IDX_W];
        w_rm_vld[j]                 = w_sh_vld[j];
      end
    end
  end

  always_comb begin
    w_sel    = r_sel;
    w_slot   = r_slot;
    w_vld    = r_vld;
    w_count  = r_count;
    w_reject = 1'b0;
    w_change = 1'b0;

    if (w_mode_chg) begin
      // Mode switch wipes the selection; any press this cycle is dropped.
      w_sel    = '0;
      w_slot   = '0;
      w_vld    = '0;
      w_count  = '0;
      w_change = (r_count != '0);
    end else if (!lock) begin
      if (w_press_multi) begin
        w_reject = 1'b1;
      end else if (w_press_one) begin
        if (r_mode == MODE_EXCL) begin
          w_change = 1'b1;
          w_slot   = '0;
          w_vld    = '0;
          if (r_sel[w_press_idx]) begin
            w_sel   = '0;
            w_count = '0;
          end else begin
            w_sel              = w_press;
            w_slot[IDX_W-1:0]  = w_press_idx;
            w_vld[0]           = 1'b1;
            w_count            = CNT_W'(1);
          end
        end else begin
          if (r_sel[w_press_idx]) begin
            w_change              = 1'b1;
            w_sel[w_press_idx]    = 1'b0;
            w_slot                = w_rm_slot;
            w_vld                 = w_rm_vld;
            w_count               = r_count - 1'b1;
          end else if (r_count == FULL_CNT) begin
            w_reject = 1'b1;
          end else begin
            w_change                         = 1'b1;
            w_sel[w_press_idx]               = 1'b1;
            w_slot[r_count*IDX_W +: IDX_W]   = w_press_idx;
            w_vld[r_count]                   = 1'b1;
            w_count                          = r_count + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    if (w_count == '0)           w_state = S_EMPTY;
    else if (w_count == FULL_CNT) w_state = S_FULL;
    else                          w_state = S_PART;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel    <= '0;
      r_slot   <= '0;
      r_vld    <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_reject <= 1'b0;
      r_change <= 1'b0;
      r_mode   <= MODE_EXCL;
      r_state  <= S_EMPTY;
    end else begin
      r_sel    <= w_sel;
      r_slot   <= w_slot;
      r_vld    <= w_vld;
      r_count  <= w_count;
      r_full   <= (w_state == S_FULL);
      r_reject <= w_reject;
      r_change <= w_change;
      r_mode   <= mode;
      r_state  <= w_state;
    end
  end

  assign rotor_sel = r_sel;
  assign slot_idx  = r_slot;
  assign slot_vld  = r_vld;
  assign sel_count = r_count;
  assign sel_full  = r_full;
  assign reject    = r_reject;
  assign change    = r_change;

endmodule

// File: tb/tb_rotor_slot_fsm.sv
// tb_rotor_slot_fsm
// Directed vector table plus hand-written multi-cycle sequences for
// rotor_slot_fsm at N_BTN=8, SLOTS=3.
module tb_rotor_slot_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] button_sync;
  logic       mode;
  logic       lock;
  logic [7:0] rotor_sel;
  logic [8:0] slot_idx;
  logic [2:0] slot_vld;
  logic [1:0] sel_count;
  logic       sel_full;
  logic       reject;
  logic       change;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rotor_slot_fsm #(
    .N_BTN (8),
    .SLOTS (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button_sync (button_sync),
    .mode        (mode),
    .lock        (lock),
    .rotor_sel   (rotor_sel),
    .slot_idx    (slot_idx),
    .slot_vld    (slot_vld),
    .sel_count   (sel_count),
    .sel_full    (sel_full),
    .reject      (reject),
    .change      (change)
  );

  // Packed observation: {sel[8], slot2[3], slot1[3], slot0[3], vld[3], cnt[2], full, rej, chg}
  typedef struct {
    logic [7:0]  btn;
    logic        md;
    logic        lk;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [24:0] pk(input logic [7:0] sel, input int s0, input int s1,
                                     input int s2, input logic [2:0] vld, input int cnt,
                                     input logic full, input logic rej, input logic chg);
    pk = {sel, 3'(s2), 3'(s1), 3'(s0), vld, 2'(cnt), full, rej, chg};
  endfunction

  function automatic vec_t V(input logic [7:0] b, input logic m, input logic l,
                             input logic [24:0] e);
    vec_t v;
    v.btn = b; v.md = m; v.lk = l; v.exp = e;
    return v;
  endfunction

  function automatic logic [24:0] obs();
    obs = {rotor_sel, slot_idx, slot_vld, sel_count, sel_full, reject, change};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic m, input logic l);
    button_sync = b; mode = m; lock = l;
    @(posedge clock); #1;
  endtask

  int nchg;
  int nrej;

  initial begin
    reset = 1'b1; button_sync = '0; mode = 1'b0; lock = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    check("reset_state", 32'(obs()), 32'(pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    reset = 1'b0;

    // Multi mode: 5,2,7 -> full; refuse 0; remove 2; lock; double press
    vecs.push_back(V(8'h00, 1, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    vecs.push_back(V(8'h20, 1, 0, pk(8'h20, 5, 0, 0, 3'b001, 1, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h20, 5, 0, 0, 3'b001, 1, 0, 0, 0)));
    vecs.push_back(V(8'h04, 1, 0, pk(8'h24, 5, 2, 0, 3'b011, 2, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h24, 5, 2, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h80, 1, 0, pk(8'hA4, 5, 2, 7, 3'b111, 3, 1, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA4, 5, 2, 7, 3'b111, 3, 1, 0, 0)));
    vecs.push_back(V(8'h01, 1, 0, pk(8'hA4, 5, 2, 7, 3'b111, 3, 1, 1, 0)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA4, 5, 2, 7, 3'b111, 3, 1, 0, 0)));
    vecs.push_back(V(8'h04, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h08, 1, 1, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h12, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 1, 0)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h12, 1, 1, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'hA0, 5, 7, 0, 3'b011, 2, 0, 0, 0)));
    // Mode 1 -> 0 with count 2 clears everything
    vecs.push_back(V(8'h00, 0, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 1)));
    // Exclusive mode: 3, 6, 6
    vecs.push_back(V(8'h08, 0, 0, pk(8'h08, 3, 0, 0, 3'b001, 1, 0, 0, 1)));
    vecs.push_back(V(8'h00, 0, 0, pk(8'h08, 3, 0, 0, 3'b001, 1, 0, 0, 0)));
    vecs.push_back(V(8'h40, 0, 0, pk(8'h40, 6, 0, 0, 3'b001, 1, 0, 0, 1)));
    vecs.push_back(V(8'h00, 0, 0, pk(8'h40, 6, 0, 0, 3'b001, 1, 0, 0, 0)));
    vecs.push_back(V(8'h40, 0, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 1)));
    vecs.push_back(V(8'h00, 0, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    // Mode change with empty list: no change pulse; press in same cycle dropped
    vecs.push_back(V(8'h02, 1, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    // Multi: 1, 3, then remove slot 0 (1) -> 3 shifts down
    vecs.push_back(V(8'h02, 1, 0, pk(8'h02, 1, 0, 0, 3'b001, 1, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h02, 1, 0, 0, 3'b001, 1, 0, 0, 0)));
    vecs.push_back(V(8'h08, 1, 0, pk(8'h0A, 1, 3, 0, 3'b011, 2, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h0A, 1, 3, 0, 3'b011, 2, 0, 0, 0)));
    vecs.push_back(V(8'h02, 1, 0, pk(8'h08, 3, 0, 0, 3'b001, 1, 0, 0, 1)));
    vecs.push_back(V(8'h00, 1, 0, pk(8'h08, 3, 0, 0, 3'b001, 1, 0, 0, 0)));

    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].md, vecs[i].lk);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
      check($sformatf("vec%0d_popcount", i), 32'($countones(rotor_sel)), 32'(sel_count));
    end

    // Held button 0x02 for 10 cycles produces exactly one event
    nchg = 0;
    for (int i = 0; i < 10; i++) begin
      step(8'h02, 1, 0);
      if (change) nchg++;
    end
    check("held_one_event", 32'(nchg), 32'd1);
    check("held_state", 32'(obs()), 32'(pk(8'h0A, 3, 1, 0, 3'b011, 2, 0, 0, 0)));
    step(8'h00, 1, 0);

    // Fill to 3, then reset while holding a button
    step(8'h01, 1, 0); step(8'h00, 1, 0);
    check("fill_full", 32'(obs()), 32'(pk(8'h0B, 3, 1, 0, 3'b111, 3, 1, 0, 0)));
    button_sync = 8'h04; mode = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    check("reset_mid_hold", 32'(obs()), 32'(pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    reset = 1'b0;
    nchg = 0; nrej = 0;
    for (int i = 0; i < 5; i++) begin
      step(8'h04, 0, 0);
      if (change) nchg++;
      if (reject) nrej++;
    end
    check("post_reset_hold_no_event", 32'(nchg + nrej), 32'd0);
    check("post_reset_hold_state", 32'(obs()), 32'(pk(8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0)));
    step(8'h00, 0, 0);
    step(8'h04, 0, 0);
    check("repress_after_reset", 32'(obs()), 32'(pk(8'h04, 2, 0, 0, 3'b001, 1, 0, 0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // reject and change are mutually exclusive at every sample point
  always @(negedge clock) begin
    if (!reset && reject && change) begin
      checks++;
      errors++;
      $display("FAIL reject_and_change: actual=%b%b required=not both", reject, change);
    end
  end

endmodule

// File: doc/rotor_slot_fsm.md
ROTOR_SLOT_FSM -- requirements
Module: rotor_slot_fsm

Interface
REQ-001 The block SHALL have parameter N_BTN, default 8, meaning number of rotor buttons (range 2..16).
REQ-002 The block SHALL have parameter SLOTS, default 3, meaning number of ordered rotor slots (range 1..N_BTN).
REQ-003 The block SHALL derive localparams IDX_W = clog2(N_BTN) and CNT_W = clog2(SLOTS+1); these are not overridable.
REQ-004 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-006 The block SHALL have port button_sync, input, N_BTN, synchronised button levels, bit i = rotor i.
REQ-007 The block SHALL have port mode, input, 1, 0 = exclusive (one rotor), 1 = ordered multi-select.
REQ-008 The block SHALL have port lock, input, 1, 1 = ignore all press events.
REQ-009 The block SHALL have port rotor_sel, output, N_BTN, bit i set iff rotor i occupies a valid slot.
REQ-010 The block SHALL have port slot_idx, output, SLOTS*IDX_W, slot k rotor index at bits [k*IDX_W +: IDX_W]; slot 0 = first selected.
REQ-011 The block SHALL have port slot_vld, output, SLOTS, bit k set iff slot k holds a rotor.
REQ-012 The block SHALL have port sel_count, output, CNT_W, number of valid slots.
REQ-013 The block SHALL have port sel_full, output, 1, high iff sel_count == SLOTS.
REQ-014 The block SHALL have port reject, output, 1, one-cycle pulse when a press event is refused.
REQ-015 The block SHALL have port change, output, 1, one-cycle pulse when rotor_sel or any slot changes.

Function
REQ-016 The block SHALL form press = button_sync & ~btn_prev, btn_prev registered every cycle including while lock=1.
REQ-017 A press event SHALL be valid only when press is one-hot; press with two or more bits set SHALL cause no state change and reject=1 (unless lock=1).
REQ-018 With lock=1 the block SHALL ignore press events, holding all state, reject=0 and change=0.
REQ-019 All outputs SHALL be registered; the edge of the cycle in which button_sync first shows the rising bit SHALL update outputs (one-cycle latency from input).
REQ-020 The FSM SHALL have states S_EMPTY (count 0), S_PART (0<count<SLOTS), S_FULL (count==SLOTS), recomputed from the post-event count.
REQ-021 Exclusive mode, press of a selected rotor SHALL clear all slots (-> S_EMPTY); press of an unselected rotor SHALL set slot 0 to it, clear other slots, count=1.
REQ-022 Multi mode, press of a selected rotor in slot k SHALL remove it, shift slots k+1..count-1 down by one, decrement count.
REQ-023 Multi mode, press of an unselected rotor with count<SLOTS SHALL append it at slot[count], increment count.
REQ-024 Multi mode, press of an unselected rotor in S_FULL SHALL be refused: reject=1, no state change.
REQ-025 Invalid slots SHALL read slot_idx field = 0 and slot_vld bit = 0; popcount(rotor_sel) SHALL equal sel_count at all times.
REQ-026 The block SHALL register mode; any change of registered mode SHALL clear all slots that cycle, with change=1 if count was nonzero; a press in that cycle SHALL be discarded without reject.
REQ-027 reject and change SHALL never both be 1 in the same cycle.

Reset
REQ-028 On reset=1 at a clock edge: rotor_sel=0, slot_idx=0, slot_vld=0, sel_count=0, sel_full=0, reject=0, change=0, btn_prev=0, mode register=0, state S_EMPTY.
REQ-029 Reset SHALL take priority over all events, including mid-press; buttons held through reset release SHALL NOT generate an event until released and re-pressed only if btn_prev captured them (btn_prev updates from the first post-reset cycle).

Structure
REQ-030 A package rotor_slot_pkg SHALL hold the state enum (S_EMPTY, S_PART, S_FULL) and mode constants MODE_EXCL=0, MODE_MULTI=1.
REQ-031 Sub-module btn_edge_detect (parameter N_BTN) SHALL implement btn_prev, press and the one-hot/multi-press classification.

Verification
REQ-032 N_BTN=8,SLOTS=3,mode=1: press 5, 2, 7 -> slot_idx 5,2,7; rotor_sel=0xA4; sel_full=1; change pulses x3.
REQ-033 From REQ-032 state press 0 -> reject=1, state unchanged; press 2 -> slots 5,7; rotor_sel=0xA0; count=2.
REQ-034 mode=0: press 3 -> rotor_sel=0x08; press 6 -> 0x40; press 6 -> 0x00, S_EMPTY.
REQ-035 Buttons 1 and 4 rise same cycle -> reject=1, no change; held button_sync=0x02 for 10 cycles -> exactly one event.
REQ-036 lock=1, press 3 -> no change, reject=0; mode 1->0 with count=2 -> all cleared, change=1.
REQ-037 reset asserted with count=3 and button held -> all outputs 0 next edge; no event until button re-rises.
